// File: rtl/binary_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and the downstream 7-segment formatting.
package binary_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_BLANK   = 4'hF;

    // True when some BIN_WIDTH-bit value can reach 10^DIGITS.
    function automatic bit ovf_possible(int bw, int d);
        longint unsigned lim;
        longint unsigned maxv;
        if (bw >= 63) return 1'b1;
        lim  = 64'd1;
        maxv = (64'd1 << bw) - 64'd1;
        for (int i = 0; i < d; i++) begin
            lim = lim * 64'd10;
            if (lim > maxv) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// Input/output valid-ready channels of the binary-to-BCD converter.
// Signal directions in the names are as seen from the converter.
interface binary_to_bcd_seq_if #(
    parameter int BIN_WIDTH = 7,
    parameter int DIGITS    = 2
);
    logic [BIN_WIDTH-1:0] i_binary;
    logic                 i_valid;
    logic                 o_ready;
    logic [4*DIGITS-1:0]  o_bcd;
    logic                 o_overflow;
    logic                 o_valid;
    logic                 i_ready;

    modport slave (
        input  i_binary, i_valid, i_ready,
        output o_ready, o_bcd, o_overflow, o_valid
    );

    modport master (
        output i_binary, i_valid, i_ready,
        input  o_ready, o_bcd, o_overflow, o_valid
    );
endinterface

// File: rtl/binary_to_bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3_digit (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative binary-to-BCD converter: one input bit per clock, with
// valid/ready on both sides and a sticky overflow flag.
module binary_to_bcd_seq
    import binary_to_bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH = 7,
    parameter int DIGITS    = 2
) (
    input logic                i_clk,
    input logic                i_reset_n,
    binary_to_bcd_seq_if.slave bus
);
    localparam int W      = BCD_DIGIT_W * DIGITS;
    localparam int CW     = $clog2(BIN_WIDTH + 1);
    localparam bit OVF_EN = ovf_possible(BIN_WIDTH, DIGITS);

    state_t               state;
    logic [BIN_WIDTH-1:0] sh;
    logic [W-1:0]         acc;
    logic [W-1:0]         acc_fix;
    logic [W-1:0]         acc_nxt;
    logic [CW-1:0]        cnt;
    logic                 sticky;
    logic                 sticky_nxt;
    logic                 ovf_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3_digit u_add3 (
            .d (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (acc_fix[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign acc_nxt    = {acc_fix[W-2:0], sh[BIN_WIDTH-1]};
    assign sticky_nxt = OVF_EN & (sticky | acc_fix[W-1]);
    // Top digit ending at 10+ is a second overflow path beside the carry-out.
    assign ovf_nxt    = sticky_nxt
                      | (OVF_EN & (acc_nxt[W-1 -: BCD_DIGIT_W] > 4'd9));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= ST_IDLE;
            bus.o_ready    <= 1'b1;
            bus.o_valid    <= 1'b0;
            bus.o_bcd      <= '0;
            bus.o_overflow <= 1'b0;
            sh             <= '0;
            acc            <= '0;
            cnt            <= '0;
            sticky         <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        sh          <= bus.i_binary;
                        acc         <= '0;
                        sticky      <= 1'b0;
                        cnt         <= CW'(BIN_WIDTH);
                        bus.o_ready <= 1'b0;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc    <= acc_nxt;
                    sh     <= sh << 1;
                    sticky <= sticky_nxt;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bus.o_overflow <= ovf_nxt;
                        bus.o_bcd      <= ovf_nxt ? {DIGITS{BCD_BLANK}}
                                                  : acc_nxt;
                        bus.o_valid    <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        bus.o_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    bus.o_valid <= 1'b0;
                    bus.o_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: 7-bit/2-digit and 8-bit/3-digit
// instances driven from a vector table plus hand-written corner sequences.
module tb_binary_to_bcd_seq;

    typedef struct {
        logic [6:0] bin;
        logic [7:0] bcd;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    binary_to_bcd_seq_if #(.BIN_WIDTH(7), .DIGITS(2)) a ();
    binary_to_bcd_seq_if #(.BIN_WIDTH(8), .DIGITS(3)) b ();

    binary_to_bcd_seq #(.BIN_WIDTH(7), .DIGITS(2)) dut_a (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (a)
    );

    binary_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut_b (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_a(input logic [6:0] v);
        int n = 0;
        while (!a.o_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("a_ready_wait", 32'(n < 50), 32'd1);
        a.i_binary = v;
        a.i_valid  = 1'b1;
        @(posedge clk); #1;
        a.i_valid  = 1'b0;
    endtask

    task automatic apply_b(input logic [7:0] v);
        int n = 0;
        while (!b.o_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("b_ready_wait", 32'(n < 50), 32'd1);
        b.i_binary = v;
        b.i_valid  = 1'b1;
        @(posedge clk); #1;
        b.i_valid  = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!a.o_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (!b.o_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handoff_a();
        a.i_ready = 1'b1;
        @(posedge clk); #1;
        a.i_ready = 1'b0;
        chk("a_handoff_valid", 32'(a.o_valid), 32'd0);
        chk("a_handoff_ready", 32'(a.o_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   lat;
        int   t0;
        int   t1;
        int   t2;
        int   cyc;
        logic [11:0] r1;
        logic [11:0] r2;

        vecs[0] = '{7'd42,  8'h42, 1'b0};
        vecs[1] = '{7'd0,   8'h00, 1'b0};
        vecs[2] = '{7'd9,   8'h09, 1'b0};
        vecs[3] = '{7'd10,  8'h10, 1'b0};
        vecs[4] = '{7'd99,  8'h99, 1'b0};
        vecs[5] = '{7'd100, 8'hFF, 1'b1};
        vecs[6] = '{7'd127, 8'hFF, 1'b1};
        vecs[7] = '{7'd63,  8'h63, 1'b0};
        vecs[8] = '{7'd85,  8'h85, 1'b0};
        vecs[9] = '{7'd50,  8'h50, 1'b0};

        a.i_binary = '0; a.i_valid = 1'b0; a.i_ready = 1'b0;
        b.i_binary = '0; b.i_valid = 1'b0; b.i_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   32'(a.o_ready),    32'd1);
        chk("rst_valid",   32'(a.o_valid),    32'd0);
        chk("rst_bcd",     32'(a.o_bcd),      32'h0);
        chk("rst_ovf",     32'(a.o_overflow), 32'd0);
        chk("rst_b_ready", 32'(b.o_ready),    32'd1);
        chk("rst_b_bcd",   32'(b.o_bcd),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            apply_a(vecs[i].bin);
            wait_a(lat);
            chk($sformatf("lat_%0d", vecs[i].bin), 32'(lat), 32'd7);
            chk($sformatf("bcd_%0d", vecs[i].bin), 32'(a.o_bcd),
                32'(vecs[i].bcd));
            chk($sformatf("ovf_%0d", vecs[i].bin), 32'(a.o_overflow),
                32'(vecs[i].ovf));
            handoff_a();
        end

        // Backpressure with a competing request held on the input.
        apply_a(7'd59);
        wait_a(lat);
        chk("bp_lat", 32'(lat), 32'd7);
        for (int i = 0; i < 5; i++) begin
            a.i_binary = 7'd33;
            a.i_valid  = 1'b1;
            @(posedge clk); #1;
            chk("bp_bcd",   32'(a.o_bcd),   32'h59);
            chk("bp_valid", 32'(a.o_valid), 32'd1);
            chk("bp_ready", 32'(a.o_ready), 32'd0);
        end
        a.i_ready = 1'b1;
        @(posedge clk); #1;
        a.i_ready = 1'b0;
        chk("bp_idle_valid", 32'(a.o_valid), 32'd0);
        chk("bp_idle_ready", 32'(a.o_ready), 32'd1);
        @(posedge clk); #1;
        a.i_valid = 1'b0;
        chk("bp_accept2", 32'(a.o_ready), 32'd0);
        wait_a(lat);
        chk("bp2_lat", 32'(lat), 32'd7);
        chk("bp2_bcd", 32'(a.o_bcd), 32'h33);
        handoff_a();

        // Asynchronous reset during the third shift of 77.
        apply_a(7'd77);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a.o_valid), 32'd0);
        chk("arst_ready", 32'(a.o_ready), 32'd1);
        chk("arst_bcd",   32'(a.o_bcd),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_no_valid", 32'(a.o_valid), 32'd0);
        apply_a(7'd12);
        wait_a(lat);
        chk("arst12_lat", 32'(lat), 32'd7);
        chk("arst12_bcd", 32'(a.o_bcd), 32'h12);
        chk("arst12_ovf", 32'(a.o_overflow), 32'd0);
        handoff_a();

        // 8-bit / 3-digit instance.
        apply_b(8'd255);
        wait_b(lat);
        chk("b255_lat", 32'(lat), 32'd8);
        chk("b255_bcd", 32'(b.o_bcd), 32'h255);
        chk("b255_ovf", 32'(b.o_overflow), 32'd0);
        b.i_ready = 1'b1;
        @(posedge clk); #1;
        b.i_ready = 1'b0;
        apply_b(8'd0);
        wait_b(lat);
        chk("b0_lat", 32'(lat), 32'd8);
        chk("b0_bcd", 32'(b.o_bcd), 32'h000);
        b.i_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back with valid and ready held high.
        b.i_binary = 8'd128;
        b.i_valid  = 1'b1;
        @(posedge clk); #1;
        b.i_binary = 8'd200;
        t0 = 0; t1 = -1; t2 = -1; cyc = 0;
        r1 = '0; r2 = '0;
        while (t2 < 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (b.o_valid) begin
                if (t1 < 0) begin
                    t1 = cyc; r1 = b.o_bcd;
                end else begin
                    t2 = cyc; r2 = b.o_bcd;
                    b.i_valid = 1'b0;
                end
            end
        end
        chk("b2b_first_lat", 32'(t1 - t0), 32'd8);
        chk("b2b_first_bcd", 32'(r1), 32'h128);
        chk("b2b_second_bcd", 32'(r2), 32'h200);
        chk("b2b_spacing", 32'(t2 - t1), 32'd10);
        b.i_valid = 1'b0;
        @(posedge clk); #1;
        b.i_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
